frog_motion_ctrl: RTL and testbench

Upstream neighbour of the VGA display stage. It turns four raw player buttons into a registered frog position in pixel coordinates, aligned to the 32-pixel cell grid, and drives the frog X/Y inputs of the display stage. Position changes are committed only on a frame tick, so a frame never shows the frog half-moved. It also detects reaching the top row, holds a win state for a fixed number of frames, then respawns the frog.

---
 rtl/frogger_pkg.sv | 23 ++
 rtl/button_debounce.sv | 45 ++++
 rtl/frog_motion_ctrl.sv | 144 ++++++++++++++
 tb/tb_frog_motion_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Grid geometry, FSM state and move-direction encodings shared by the frog
// motion controller and the display stage.
package frogger_pkg;

    localparam int GRID_SIZE = 32;
    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int START_COL = 9;
    localparam int START_ROW = 14;

    typedef enum logic {
        PLAY = 1'b0,
        WIN  = 1'b1
    } frog_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

endpackage

// File: rtl/button_debounce.sv
// Raw button -> 2-FF sync -> debounced level -> one-cycle rising-edge pulse.
// Latency 2 + DEBOUNCE_CYCLES + 1 cycles from raw edge to sampled pulse; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Btn,
    output logic o_Press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= i_Btn;
            sync_q2 <= sync_q1;
            level_q <= level;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign o_Press = level & ~level_q;

endmodule

// File: rtl/frog_motion_ctrl.sv
// Buttons -> pending move -> grid position committed on frame ticks, with a timed win/respawn.
// Outputs update one cycle after i_Frame_Tick only; extra presses are dropped while a move is pending.
module frog_motion_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GRID_SIZE       = frogger_pkg::GRID_SIZE,
    parameter int GRID_COLS       = frogger_pkg::GRID_COLS,
    parameter int GRID_ROWS       = frogger_pkg::GRID_ROWS,
    parameter int START_COL       = frogger_pkg::START_COL,
    parameter int START_ROW       = frogger_pkg::START_ROW,
    parameter int WIN_HOLD_FRAMES = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Left,
    input  logic       i_Right,
    input  logic       i_Frame_Tick,
    output logic [9:0] o_Frog_X,
    output logic [9:0] o_Frog_Y,
    output logic       o_Win,
    output logic [3:0] o_Win_Count
);

    import frogger_pkg::*;

    localparam int FCW = (WIN_HOLD_FRAMES < 2) ? 1 : $clog2(WIN_HOLD_FRAMES + 1);

    logic [3:0]     press;
    logic           press_vld;
    dir_t           press_dir;

    frog_state_t    state;
    logic [4:0]     col;
    logic [3:0]     row;
    logic           pend_vld;
    dir_t           pend_dir;
    logic [FCW-1:0] frame_cnt;

    logic [4:0]     tgt_col;
    logic [3:0]     tgt_row;
    logic           tgt_ok;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Btn(i_Up), .o_Press(press[0])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Btn(i_Down), .o_Press(press[1])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Btn(i_Left), .o_Press(press[2])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Btn(i_Right), .o_Press(press[3])
    );

    always_comb begin
        press_vld = |press;
        if (press[0])      press_dir = DIR_UP;
        else if (press[1]) press_dir = DIR_DOWN;
        else if (press[2]) press_dir = DIR_LEFT;
        else               press_dir = DIR_RIGHT;

        tgt_col = col;
        tgt_row = row;
        tgt_ok  = 1'b0;
        case (pend_dir)
            DIR_UP: begin
                tgt_row = row - 4'd1;
                tgt_ok  = (row != 4'd0);
            end
            DIR_DOWN: begin
                tgt_row = row + 4'd1;
                tgt_ok  = (int'(row) < GRID_ROWS - 1);
            end
            DIR_LEFT: begin
                tgt_col = col - 5'd1;
                tgt_ok  = (col != 5'd0);
            end
            DIR_RIGHT: begin
                tgt_col = col + 5'd1;
                tgt_ok  = (int'(col) < GRID_COLS - 1);
            end
            default: tgt_ok = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= PLAY;
            col         <= 5'(START_COL);
            row         <= 4'(START_ROW);
            pend_vld    <= 1'b0;
            pend_dir    <= DIR_UP;
            frame_cnt   <= '0;
            o_Frog_X    <= 10'(START_COL * GRID_SIZE);
            o_Frog_Y    <= 10'(START_ROW * GRID_SIZE);
            o_Win       <= 1'b0;
            o_Win_Count <= 4'd0;
        end else begin
            case (state)
                PLAY: begin
                    if (i_Frame_Tick && pend_vld) begin
                        // A press landing on the consuming tick becomes the next pending move.
                        pend_vld <= press_vld;
                        pend_dir <= press_dir;
                        if (tgt_ok) begin
                            col      <= tgt_col;
                            row      <= tgt_row;
                            o_Frog_X <= 10'(int'(tgt_col) * GRID_SIZE);
                            o_Frog_Y <= 10'(int'(tgt_row) * GRID_SIZE);
                            if (tgt_row == 4'd0) begin
                                state       <= WIN;
                                o_Win       <= 1'b1;
                                o_Win_Count <= o_Win_Count + 4'd1;
                                frame_cnt   <= FCW'(WIN_HOLD_FRAMES);
                                pend_vld    <= 1'b0;
                            end
                        end
                    end else if (press_vld && !pend_vld) begin
                        pend_vld <= 1'b1;
                        pend_dir <= press_dir;
                    end
                end
                WIN: begin
                    pend_vld <= 1'b0;
                    if (i_Frame_Tick) begin
                        frame_cnt <= frame_cnt - FCW'(1);
                        if (frame_cnt == FCW'(1)) begin
                            state    <= PLAY;
                            col      <= 5'(START_COL);
                            row      <= 4'(START_ROW);
                            o_Frog_X <= 10'(START_COL * GRID_SIZE);
                            o_Frog_Y <= 10'(START_ROW * GRID_SIZE);
                            o_Win    <= 1'b0;
                        end
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Directed scenarios plus randomized presses/ticks against a grid-level reference model.
module tb_frog_motion_ctrl;

    localparam int DB = 4;
    localparam int WH = 3;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b1;
    logic       i_Up = 1'b0, i_Down = 1'b0, i_Left = 1'b0, i_Right = 1'b0;
    logic       i_Frame_Tick = 1'b0;
    logic [9:0] o_Frog_X, o_Frog_Y;
    logic       o_Win;
    logic [3:0] o_Win_Count;

    int total = 0;
    int bad = 0;

    // Reference model: grid cell, one-slot pending move, win hold.
    int m_col, m_row, m_pend, m_dir, m_win, m_frames, m_wins;

    always #20 i_Clk = ~i_Clk;

    frog_motion_ctrl #(.DEBOUNCE_CYCLES(DB), .WIN_HOLD_FRAMES(WH)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
        .i_Up(i_Up), .i_Down(i_Down), .i_Left(i_Left), .i_Right(i_Right),
        .i_Frame_Tick(i_Frame_Tick),
        .o_Frog_X(o_Frog_X), .o_Frog_Y(o_Frog_Y),
        .o_Win(o_Win), .o_Win_Count(o_Win_Count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},   32'(o_Frog_X),    32'(m_col * 32));
        chk({tag, ".y"},   32'(o_Frog_Y),    32'(m_row * 32));
        chk({tag, ".win"}, 32'(o_Win),       32'(m_win));
        chk({tag, ".cnt"}, 32'(o_Win_Count), 32'(m_wins % 16));
    endtask

    task automatic model_reset();
        m_col = 9; m_row = 14; m_pend = 0; m_dir = 0;
        m_win = 0; m_frames = 0; m_wins = 0;
    endtask

    // mask bits: 0=up 1=down 2=left 3=right, lower bit wins
    task automatic model_press(input logic [3:0] mask);
        if (m_win == 0 && m_pend == 0 && mask != 4'd0) begin
            m_pend = 1;
            for (int b = 3; b >= 0; b--)
                if (mask[b]) m_dir = b;
        end
    endtask

    task automatic model_tick();
        int nc, nr;
        if (m_win != 0) begin
            m_frames--;
            if (m_frames == 0) begin
                m_win = 0; m_col = 9; m_row = 14;
            end
        end else if (m_pend != 0) begin
            nc = m_col; nr = m_row;
            case (m_dir)
                0: nr--;
                1: nr++;
                2: nc--;
                default: nc++;
            endcase
            m_pend = 0;
            if (nc >= 0 && nc < 20 && nr >= 0 && nr < 15) begin
                m_col = nc; m_row = nr;
                if (nr == 0) begin
                    m_win = 1; m_wins++; m_frames = WH;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] mask);
        {i_Right, i_Left, i_Down, i_Up} = mask;
    endtask

    task automatic press(input logic [3:0] mask);
        set_btn(mask);
        repeat (10) step();
        set_btn(4'd0);
        repeat (10) step();
        model_press(mask);
        check_all("press");
    endtask

    task automatic glitch(input logic [3:0] mask);
        set_btn(mask);
        repeat (2) step();
        set_btn(4'd0);
        repeat (10) step();
        check_all("glitch");
    endtask

    task automatic tick();
        i_Frame_Tick = 1'b1;
        step();
        i_Frame_Tick = 1'b0;
        model_tick();
        check_all("tick");
    endtask

    initial begin
        logic [3:0] mask;
        int r;

        model_reset();
        #1 i_Rst_L = 1'b0;
        #2 check_all("reset");
        repeat (3) step();
        i_Rst_L = 1'b1;
        step();

        // idle frames
        for (int i = 0; i < 10; i++) begin
            repeat (5) step();
            tick();
        end

        // single up, then a short glitch that must not move
        press(4'b0001);
        tick();
        chk("up_y416", 32'(o_Frog_Y), 32'd416);
        glitch(4'b1000);
        tick();

        // walk to column 0, bump the left wall, then move right
        for (int i = 0; i < 10; i++) begin
            press(4'b0100);
            tick();
        end
        chk("left_wall_x0", 32'(o_Frog_X), 32'd0);
        press(4'b1000);
        tick();
        chk("right_after_wall", 32'(o_Frog_X), 32'd32);

        // simultaneous up+right: up wins, next tick idle
        press(4'b1001);
        tick();
        tick();

        // press coinciding with the consuming tick becomes the next pending move
        press(4'b0001);
        set_btn(4'b1000);
        repeat (6) step();
        i_Frame_Tick = 1'b1;
        step();
        i_Frame_Tick = 1'b0;
        model_tick();
        model_press(4'b1000);
        repeat (3) step();
        set_btn(4'd0);
        repeat (10) step();
        check_all("overlap");
        tick();

        // climb to the top row, win hold with ignored presses, respawn
        for (int i = 0; i < 20 && m_win == 0; i++) begin
            press(4'b0001);
            tick();
        end
        chk("win_hi", 32'(o_Win), 32'd1);
        press(4'b0010);
        for (int i = 0; i < WH; i++) tick();
        chk("respawn_x", 32'(o_Frog_X), 32'd288);
        chk("respawn_y", 32'(o_Frog_Y), 32'd448);
        chk("respawn_win", 32'(o_Win), 32'd0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                mask = 4'd0;
                mask[$urandom_range(0, 3)] = 1'b1;
                press(mask);
            end else if (r == 6) begin
                mask = 4'($urandom_range(1, 15));
                press(mask);
            end else if (r == 7) begin
                mask = 4'($urandom_range(1, 15));
                glitch(mask);
            end else begin
                repeat (3) step();
            end
            if ($urandom_range(0, 2) != 0) tick();
        end

        // reach WIN again, then async reset between edges
        for (int i = 0; i < 40 && m_win == 0; i++) begin
            press(4'b0001);
            tick();
        end
        chk("win_before_rst", 32'(o_Win), 32'd1);
        press(4'b0001);
        #3 i_Rst_L = 1'b0;
        model_reset();
        #2 check_all("async_rst");
        step();
        i_Rst_L = 1'b1;
        step();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
